// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and parameter limits for the IJTAG/functional data mux arbiter.
package firebird7_in_gate1_tessent_data_mux_pkg;

    typedef enum logic [2:0] {
        ST_FUNC,
        ST_DRAIN,
        ST_SET_IJ,
        ST_IJTAG,
        ST_SET_FN
    } state_t;

    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int DRAIN_MIN  = 1;
    localparam int DRAIN_MAX  = 255;
    localparam int HOLD_MIN   = 0;
    localparam int HOLD_MAX   = 15;

    // Counter widths sized for the largest legal limit.
    localparam int SETTLE_W = $clog2(SETTLE_MAX + 1);
    localparam int DRAIN_W  = $clog2(DRAIN_MAX + 1);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [7:0] SWITCH_MAX = 8'hFF;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_cnt.sv
// Cycle counter with clear, enable and saturation at LIMIT; done is high in the
// cycle that completes LIMIT counted cycles (always high when LIMIT is 0).
module firebird7_in_gate1_tessent_data_mux_cnt #(
    parameter int W         = 4,
    parameter int LIMIT     = 2,
    parameter int RESET_VAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [W:0]   LIMIT_X = (W + 1)'(LIMIT);
    localparam logic [W:0]   ONE_X   = (W + 1)'(1);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= W'(RESET_VAL);
        end else if (clr) begin
            count <= '0;
        end else if (en && ({1'b0, count} < LIMIT_X)) begin
            count <= count + ONE;
        end
    end

    assign done = ({1'b0, count} + ONE_X) >= LIMIT_X;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_arbiter.sv
// Hands the external data mux between functional and IJTAG owners, draining
// functional traffic first and holding the select stable with no grant around each switch.
module firebird7_in_gate1_tessent_data_mux_arbiter
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 2,
    parameter int DRAIN_TIMEOUT   = 64,
    parameter int MIN_FUNC_CYCLES = 4
) (
    input  logic       ijtag_tck,
    input  logic       ijtag_reset,
    input  logic       ijtag_req,
    input  logic       func_busy,
    output logic       ijtag_select,
    output logic       ijtag_gnt,
    output logic       func_gnt,
    output logic       drain_timeout_err,
    output logic [7:0] switch_count
);

    state_t state;
    state_t next_state;
    logic   settle_done;
    logic   drain_done;
    logic   hold_done;
    logic   timeout_hit;

    firebird7_in_gate1_tessent_data_mux_cnt #(
        .W(SETTLE_W), .LIMIT(SETTLE_CYCLES), .RESET_VAL(0)
    ) u_settle_cnt (
        .clk(ijtag_tck), .rst(ijtag_reset),
        .clr(next_state != state),
        .en((state == ST_SET_IJ) || (state == ST_SET_FN)),
        .done(settle_done)
    );

    firebird7_in_gate1_tessent_data_mux_cnt #(
        .W(DRAIN_W), .LIMIT(DRAIN_TIMEOUT), .RESET_VAL(0)
    ) u_drain_cnt (
        .clk(ijtag_tck), .rst(ijtag_reset),
        .clr(state != ST_DRAIN),
        .en(state == ST_DRAIN),
        .done(drain_done)
    );

    // Preset at reset so the first request after reset is not held off.
    firebird7_in_gate1_tessent_data_mux_cnt #(
        .W(HOLD_W), .LIMIT(MIN_FUNC_CYCLES), .RESET_VAL(MIN_FUNC_CYCLES)
    ) u_hold_cnt (
        .clk(ijtag_tck), .rst(ijtag_reset),
        .clr((state == ST_SET_FN) && (next_state == ST_FUNC)),
        .en(state == ST_FUNC),
        .done(hold_done)
    );

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state <= ST_FUNC;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_FUNC:   if (ijtag_req && hold_done) next_state = ST_DRAIN;
            ST_DRAIN: begin
                if (!ijtag_req)                   next_state = ST_FUNC;
                else if (!func_busy || drain_done) next_state = ST_SET_IJ;
            end
            ST_SET_IJ: if (settle_done) next_state = ijtag_req ? ST_IJTAG : ST_SET_FN;
            ST_IJTAG:  if (!ijtag_req)  next_state = ST_SET_FN;
            ST_SET_FN: if (settle_done) next_state = ST_FUNC;
            default:   next_state = ST_FUNC;
        endcase
    end

    // A drain that ends with the functional side still busy was forced.
    assign timeout_hit = (state == ST_DRAIN) && ijtag_req && func_busy && drain_done;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            drain_timeout_err <= 1'b0;
            switch_count      <= '0;
        end else begin
            if (timeout_hit) begin
                drain_timeout_err <= 1'b1;
            end
            if ((next_state == ST_IJTAG) && (state != ST_IJTAG) && (switch_count != SWITCH_MAX)) begin
                switch_count <= switch_count + 8'd1;
            end
        end
    end

    always_comb begin
        ijtag_select = 1'b0;
        ijtag_gnt    = 1'b0;
        func_gnt     = 1'b0;
        case (state)
            ST_FUNC:   func_gnt = 1'b1;
            ST_SET_IJ: ijtag_select = 1'b1;
            ST_IJTAG: begin
                ijtag_select = 1'b1;
                ijtag_gnt    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
